// File: rtl/taylor_pkg.sv
// Shared types and constants for the Taylor-series sine/cosine unit.
package taylor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        HORNER,
        SCALE
    } state_t;

    localparam int W_DEFAULT     = 24;
    localparam int FRAC_DEFAULT  = 10;
    localparam int TERMS_DEFAULT = 4;
    localparam int MAX_TERMS     = 6;

    // round(2^frac / n!) evaluated at elaboration time
    function automatic int coef(input int n, input int frac);
        longint fact;
        longint num;
        fact = 1;
        for (int i = 2; i <= n; i++) begin
            fact = fact * i;
        end
        num = longint'(1) << frac;
        return int'((2 * num + fact) / (2 * fact));
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// saturate back to W bits with an overflow flag.
module fxp_mul_sat #(
    parameter int W    = 24,
    parameter int FRAC = 10
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;

    assign prod    = a * b;
    assign shifted = prod >>> FRAC;

    // Fits in W bits only when every bit from W-1 upward is a sign copy
    assign ovf = !((&shifted[2*W-1:W-1]) || !(|shifted[2*W-1:W-1]));
    assign p   = ovf ? (shifted[2*W-1] ? MIN_VAL : MAX_VAL) : shifted[W-1:0];

endmodule

// File: rtl/taylor_trig_unit.sv
// Sine/cosine by Horner evaluation of a truncated Taylor series in x^2,
// one multiply per clock through a single shared saturating multiplier.
module taylor_trig_unit
    import taylor_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int FRAC  = FRAC_DEFAULT,
    parameter int TERMS = TERMS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] angle,
    output logic                ready,
    output logic                done,
    output logic signed [W-1:0] result,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    localparam logic signed [W-1:0] COS_C [0:MAX_TERMS-1] = '{
        W'(coef(0, FRAC)), W'(coef(2, FRAC)), W'(coef(4, FRAC)),
        W'(coef(6, FRAC)), W'(coef(8, FRAC)), W'(coef(10, FRAC))
    };
    localparam logic signed [W-1:0] SIN_C [0:MAX_TERMS-1] = '{
        W'(coef(1, FRAC)), W'(coef(3, FRAC)), W'(coef(5, FRAC)),
        W'(coef(7, FRAC)), W'(coef(9, FRAC)), W'(coef(11, FRAC))
    };

    state_t              state, state_nxt;
    logic signed [W-1:0] angle_r, angle_nxt;
    logic                mode_r, mode_nxt;
    logic signed [W-1:0] x2, x2_nxt;
    logic signed [W-1:0] acc, acc_nxt;
    logic [2:0]          k, k_nxt;
    logic                ovf_acc, ovf_acc_nxt;
    logic signed [W-1:0] result_nxt;
    logic                ovf_nxt;
    logic                done_nxt;

    logic signed [W-1:0] mul_a, mul_b, mul_p;
    logic                mul_ovf;
    logic [2:0]          coef_idx;
    logic signed [W-1:0] coef_k;
    logic signed [W:0]   diff;
    logic                sub_ovf;
    logic signed [W-1:0] sub_sat;

    fxp_mul_sat #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Operand steering kept apart from the FSM so the multiplier stays a pure feed-forward path
    always_comb begin
        mul_a = acc;
        mul_b = x2;
        case (state)
            SQUARE: begin
                mul_a = angle_r;
                mul_b = angle_r;
            end
            SCALE: begin
                mul_a = acc;
                mul_b = angle_r;
            end
            default: ;
        endcase
    end

    assign coef_idx = (state == SQUARE) ? 3'(TERMS - 1) : k;
    assign coef_k   = mode_r ? SIN_C[coef_idx] : COS_C[coef_idx];

    assign diff    = {coef_k[W-1], coef_k} - {mul_p[W-1], mul_p};
    assign sub_ovf = diff[W] ^ diff[W-1];
    assign sub_sat = sub_ovf ? (diff[W] ? MIN_VAL : MAX_VAL) : diff[W-1:0];

    assign ready = (state == IDLE);

    always_comb begin
        state_nxt   = state;
        angle_nxt   = angle_r;
        mode_nxt    = mode_r;
        x2_nxt      = x2;
        acc_nxt     = acc;
        k_nxt       = k;
        ovf_acc_nxt = ovf_acc;
        result_nxt  = result;
        ovf_nxt     = ovf;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    angle_nxt = angle;
                    mode_nxt  = mode;
                    state_nxt = SQUARE;
                end
            end
            SQUARE: begin
                x2_nxt      = mul_p;
                acc_nxt     = coef_k;
                ovf_acc_nxt = mul_ovf;
                k_nxt       = 3'(TERMS - 2);
                state_nxt   = HORNER;
            end
            HORNER: begin
                acc_nxt     = sub_sat;
                ovf_acc_nxt = ovf_acc | mul_ovf | sub_ovf;
                if (k == 3'd0) begin
                    if (mode_r) begin
                        state_nxt = SCALE;
                    end else begin
                        result_nxt = sub_sat;
                        ovf_nxt    = ovf_acc | mul_ovf | sub_ovf;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    k_nxt = k - 3'd1;
                end
            end
            SCALE: begin
                result_nxt = mul_p;
                ovf_nxt    = ovf_acc | mul_ovf;
                done_nxt   = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            angle_r <= '0;
            mode_r  <= 1'b0;
            x2      <= '0;
            acc     <= '0;
            k       <= '0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            angle_r <= angle_nxt;
            mode_r  <= mode_nxt;
            x2      <= x2_nxt;
            acc     <= acc_nxt;
            k       <= k_nxt;
            ovf_acc <= ovf_acc_nxt;
            result  <= result_nxt;
            ovf     <= ovf_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_taylor_trig_unit.sv
// Directed checks of taylor_trig_unit: default build plus a W=16 build for saturation.
module tb_taylor_trig_unit;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               mode;
    logic signed [23:0] angle;
    logic               ready;
    logic               done;
    logic signed [23:0] result;
    logic               ovf;

    logic               start16;
    logic signed [15:0] angle16;
    logic               ready16;
    logic               done16;
    logic signed [15:0] result16;
    logic               ovf16;

    int checks = 0;
    int passed = 0;

    taylor_trig_unit u_dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .angle  (angle),
        .ready  (ready),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    taylor_trig_unit #(
        .W     (16),
        .FRAC  (10),
        .TERMS (4)
    ) u_dut16 (
        .clock  (clock),
        .reset  (reset),
        .start  (start16),
        .mode   (1'b0),
        .angle  (angle16),
        .ready  (ready16),
        .done   (done16),
        .result (result16),
        .ovf    (ovf16)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic issue(input logic m, input logic signed [23:0] a);
        start = 1'b1;
        mode  = m;
        angle = a;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clock);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        angle   = '0;
        start16 = 1'b0;
        angle16 = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_ready",  ready,  1);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        check("rst_ovf",    ovf,    0);

        issue(1'b0, 24'sd0);
        wait_done(lat);
        check("cos0_lat", lat,    4);
        check("cos0_res", result, 1024);
        check("cos0_ovf", ovf,    0);
        @(posedge clock);
        #1;
        check("cos0_done_width", done, 0);

        issue(1'b0, 24'sd1024);
        wait_done(lat);
        check("cos1_lat", lat,    4);
        check("cos1_res", result, 554);
        check("cos1_ovf", ovf,    0);

        issue(1'b1, 24'sd1024);
        wait_done(lat);
        check("sin1_lat",        lat,    5);
        check("sin1_res",        result, 862);
        check("sin1_ready_done", ready,  1);
        issue(1'b1, -24'sd1024);
        wait_done(lat);
        check("sinm1_lat", lat,    5);
        check("sinm1_res", result, -862);
        check("sinm1_ovf", ovf,    0);

        repeat (3) @(posedge clock);
        #1;
        check("hold_res", result, -862);

        issue(1'b0, 24'sd1024);
        @(posedge clock);
        #1;
        start = 1'b1;
        mode  = 1'b1;
        angle = 24'sd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat + 2, 4);
        check("ign_res", result,  554);
        count_dones(8, cnt);
        check("ign_extra_done", cnt, 0);

        issue(1'b0, 24'sd1024);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_ready",  ready,  1);
        check("abort_done",   done,   0);
        check("abort_result", result, 0);
        check("abort_ovf",    ovf,    0);
        count_dones(8, cnt);
        check("abort_no_done", cnt, 0);

        start16 = 1'b1;
        angle16 = 16'sh7FFF;
        @(posedge clock);
        #1;
        start16 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            #1;
            if (done16) begin
                lat = n;
                break;
            end
        end
        check("w16_lat", lat,      4);
        check("w16_ovf", ovf16,    1);
        check("w16_res", result16, -3103);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/taylor_trig_unit.md
TAYLOR_TRIG_UNIT -- requirements
Module: taylor_trig_unit

Interface
REQ-001 SHALL have parameter W, default 24, meaning signed word width of angle, result and all internal registers.
REQ-002 SHALL have parameter FRAC, default 10, meaning number of fractional bits in the Q(W-FRAC).FRAC fixed-point format; legal range 4..W-4.
REQ-003 SHALL have parameter TERMS, default 4, meaning number of series terms evaluated; legal range 2..6.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; sampled only when ready=1.
REQ-007 SHALL have port mode  input  1  0 = cosine, 1 = sine; sampled with start.
REQ-008 SHALL have port angle  input  W  signed Q-format angle in radians; sampled with start.
REQ-009 SHALL have port ready  output  1  high iff the unit is in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result and ovf are valid from this cycle.
REQ-011 SHALL have port result  output  W  signed Q-format cos or sin of angle.
REQ-012 SHALL have port ovf  output  1  set if any saturation occurred during the operation that produced result.

Function
REQ-013 SHALL implement states IDLE, SQUARE, HORNER, SCALE, DONE-free: done is a registered pulse issued on the last compute edge; the FSM returns to IDLE on that same edge.
REQ-014 SHALL, on an edge with state=IDLE and start=1, capture angle and mode into internal registers and enter SQUARE; start=0 in IDLE keeps IDLE.
REQ-015 SHALL, in SQUARE, compute x2 = sat((angle*angle) >>> FRAC), load acc = C[TERMS-1], clear the ovf accumulator, and enter HORNER with step counter k = TERMS-2.
REQ-016 SHALL, in HORNER, update acc = sat(C[k] - sat((acc*x2) >>> FRAC)) each edge, decrementing k; after the k=0 step go to SCALE if mode=1, else write result=acc, pulse done, return to IDLE.
REQ-017 SHALL, in SCALE, write result = sat((acc*angle) >>> FRAC), pulse done, return to IDLE.
REQ-018 SHALL use C[k] = round(2^FRAC/(2k)!) for cosine and round(2^FRAC/(2k+1)!) for sine.
REQ-019 SHALL form every product at full 2W-bit signed width, arithmetic-shift right by FRAC (truncate toward minus infinity), then saturate to W-bit signed range; any saturation sets the ovf accumulator.
REQ-020 SHALL give latency, from the edge sampling start to the edge raising done, of TERMS edges for cosine and TERMS+1 edges for sine.
REQ-021 SHALL ignore start while ready=0; captured angle/mode SHALL not change mid-operation.
REQ-022 SHALL accept start in the cycle done is high (ready is also high), giving back-to-back operation with no idle cycle.
REQ-023 SHALL hold result and ovf unchanged between done pulses.
REQ-024 SHALL perform no range reduction; accuracy outside |angle| <= pi is the caller's responsibility.

Reset
REQ-025 SHALL, on reset=1 at any edge including mid-operation, enter IDLE, abort the operation, and set done=0, result=0, ovf=0; ready=1 from the following cycle.
REQ-026 SHALL give reset priority over start in the same edge.

Structure
REQ-027 SHALL place the state enum, default W/FRAC/TERMS constants and a constant function coef(n, frac) returning round(2^frac/n!) in package taylor_pkg.
REQ-028 SHALL instantiate one sub-module fxp_mul_sat (W, FRAC parameters: signed multiply, shift, saturate, overflow flag), shared by all states.

Verification
REQ-029 cos, angle=0 -> done after 4 edges, result=1024, ovf=0.
REQ-030 cos, angle=1024 (1.0 rad) -> done after 4 edges, result=554, ovf=0.
REQ-031 sin, angle=1024 then back-to-back sin, angle=-1024 (start held high on done cycle) -> results 862 then -862, each after 5 edges.
REQ-032 start pulsed during HORNER -> ignored, single done, result unchanged from in-flight operation.
REQ-033 reset asserted in the HORNER step of a cos op -> next cycle ready=1, done=0, result=0, no later done pulse.
REQ-034 W=16, cos, angle=16'h7FFF -> x2 saturates to 32767, ovf=1 at done.
